// File: rtl/rng_pkg.sv
// rng_pkg: shared definitions for the random-number arbiter slice.
//   - LFSR width, default seed and feedback tap mask
//   - arbiter FSM state enum
//   - mask_for(): smallest all-ones mask covering an inclusive upper bound
package rng_pkg;

  localparam int unsigned LfsrWidth = 8;
  localparam logic [LfsrWidth-1:0] DefaultSeed = 8'hDA;
  // Feedback is q[7]^q[5]^q[4]^q[3]: maximal length, never reaches zero from a nonzero seed.
  localparam logic [LfsrWidth-1:0] LfsrTaps = 8'b1011_1000;

  typedef enum logic [1:0] {StIdle, StDraw, StCheck, StResp} state_e;

  // Smear the highest set bit downwards: 0 -> 0x00, 4 -> 0x07, 0x0F -> 0x0F, 0xFF -> 0xFF.
  function automatic logic [LfsrWidth-1:0] mask_for(input logic [LfsrWidth-1:0] max_val);
    logic [LfsrWidth-1:0] m;
    m = max_val;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

// File: rtl/rng_arbiter_if.sv
// rng_arbiter_if: request/response bundle between game-logic requesters and rng_arbiter.
//   req      requester -> arbiter  per-requester request level
//   req_max  requester -> arbiter  inclusive upper bound, slice i = [8i+7:8i]
//   ack      arbiter -> requester  one-cycle one-hot result strobe
//   rnd_data arbiter -> requester  result, valid while any ack bit is high
//   rnd_id   arbiter -> requester  index of the acknowledged requester
//   busy     arbiter -> requester  high whenever the arbiter is not idle
interface rng_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_max;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         rnd_data;
  logic [IdW-1:0]     rnd_id;
  logic               busy;

  modport master (
    output req, req_max,
    input  ack, rnd_data, rnd_id, busy
  );

  modport slave (
    input  req, req_max,
    output ack, rnd_data, rnd_id, busy
  );
endinterface

// File: rtl/rng_lfsr_core.sv
// rng_lfsr_core: 8-bit Fibonacci LFSR, the single random source of the arbiter.
//   clk, rst     clock, asynchronous active-high reset (loads Seed)
//   i_en         advance one step
//   i_load       load i_load_val (a zero value falls back to Seed); wins over i_en
//   i_load_val   value to load
//   o_q          current LFSR state
module rng_lfsr_core
  import rng_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] Seed = DefaultSeed
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic [LfsrWidth-1:0] i_load_val,
  output logic [LfsrWidth-1:0] o_q
);

  logic [LfsrWidth-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= Seed;
    end else if (i_load) begin
      // An all-zero state would lock the LFSR, so substitute the default seed.
      r_q <= (i_load_val == '0) ? Seed : i_load_val;
    end else if (i_en) begin
      r_q <= {r_q[LfsrWidth-2:0], ^(r_q & LfsrTaps)};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin arbiter sharing one LFSR between N_REQ requesters. Each grant
// returns a value in [0, req_max] by masked rejection sampling; after MAX_TRIES rejected
// candidates the last candidate minus (max+1) is returned instead.
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     req/req_max in, ack/rnd_data/rnd_id/busy out (see rng_arbiter_if)
//   seed_load, seed only with RNG_RESEED_EN defined: reload the LFSR while idle
// Build option: RNG_RESEED_EN adds the seed_load/seed reseed ports.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int unsigned          N_REQ     = 4,
  parameter int unsigned          MAX_TRIES = 4,
  parameter logic [LfsrWidth-1:0] SEED      = DefaultSeed
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef RNG_RESEED_EN
  input  logic                 seed_load,
  input  logic [LfsrWidth-1:0] seed,
`endif
  rng_arbiter_if.slave         bus
);

  localparam int unsigned IdW = $clog2(N_REQ);
  localparam logic [3:0] MaxTries = 4'(MAX_TRIES);

  state_e           r_state;
  logic [IdW-1:0]   r_idx;
  logic [IdW-1:0]   r_ptr;
  logic [7:0]       r_max;
  logic [7:0]       r_mask;
  logic [3:0]       r_tries;
  logic [N_REQ-1:0] r_ack;
  logic [7:0]       r_data;
  logic [IdW-1:0]   r_id;
  logic             r_busy;

  logic [7:0]         w_lfsr_q;
  logic               w_step;
  logic               w_load;
  logic [7:0]         w_load_val;
  logic [2*N_REQ-1:0] w_req2;
  logic               w_grant_vld;
  logic [IdW-1:0]     w_grant_idx;
  logic [7:0]         w_grant_max;
  logic [7:0]         w_cand;
  logic               w_accept;
  logic [7:0]         w_result;

`ifdef RNG_RESEED_EN
  assign w_load     = seed_load && (r_state == StIdle);
  assign w_load_val = seed;
`else
  assign w_load     = 1'b0;
  assign w_load_val = '0;
`endif

  assign w_step = (r_state == StDraw);

  rng_lfsr_core #(
    .Seed (SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_step),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_q        (w_lfsr_q)
  );

  // Doubling the request vector lets the search from r_ptr wrap without modular indexing.
  assign w_req2 = {bus.req, bus.req};

  // Walk offsets from the far end so the lowest offset from r_ptr wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_req2[int'(r_ptr) + i]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IdW'((int'(r_ptr) + i) % int'(N_REQ));
      end
    end
  end

  assign w_grant_max = bus.req_max[{w_grant_idx, 3'b000} +: 8];

  assign w_cand   = w_lfsr_q & r_mask;
  assign w_accept = (w_cand <= r_max);
  // Fallback stays in range because the mask never exceeds 2*max+1.
  assign w_result = w_accept ? w_cand : (w_cand - r_max - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_max   <= '0;
      r_mask  <= '0;
      r_tries <= '0;
      r_ack   <= '0;
      r_data  <= '0;
      r_id    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        StIdle: begin
          // A reseed cycle takes precedence over granting.
          if (!w_load && w_grant_vld) begin
            r_idx   <= w_grant_idx;
            r_max   <= w_grant_max;
            r_mask  <= mask_for(w_grant_max);
            r_tries <= '0;
            r_busy  <= 1'b1;
            r_state <= StDraw;
          end
        end
        StDraw: begin
          r_tries <= r_tries + 4'd1;
          r_state <= StCheck;
        end
        StCheck: begin
          if (w_accept || (r_tries == MaxTries)) begin
            r_data  <= w_result;
            r_ack   <= N_REQ'(1) << r_idx;
            r_id    <= r_idx;
            r_state <= StResp;
          end else begin
            r_state <= StDraw;
          end
        end
        StResp: begin
          r_ptr   <= (r_idx == IdW'(N_REQ - 1)) ? '0 : r_idx + IdW'(1);
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.rnd_data = r_data;
  assign bus.rnd_id   = r_id;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: self-checking bench for rng_arbiter. Directed vector table, hand-written
// corner sequences, then randomized multi-requester rounds against a behavioural model.
module tb_rng_arbiter;

  localparam int Limit = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  rng_arbiter_if #(.N_REQ(4)) if0 ();
  rng_arbiter_if #(.N_REQ(4)) if1 ();

`ifdef RNG_RESEED_EN
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       seed_load1 = 1'b0;
  logic [7:0] seed1 = 8'h00;
`endif

  rng_arbiter #(.N_REQ(4), .MAX_TRIES(4), .SEED(8'hDA)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RNG_RESEED_EN
    .seed_load (seed_load),
    .seed      (seed),
`endif
    .bus       (if0)
  );

  rng_arbiter #(.N_REQ(4), .MAX_TRIES(1), .SEED(8'hDA)) dut1 (
    .clk       (clk),
    .rst       (rst),
`ifdef RNG_RESEED_EN
    .seed_load (seed_load1),
    .seed      (seed1),
`endif
    .bus       (if1)
  );

  typedef struct {
    int         id;
    logic [7:0] mx;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  task automatic do_reset();
    if0.req = '0;
    if1.req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Single request from requester id; returns result, latency in edges, ack vector,
  // busy after the grant edge and ack one cycle after the pulse.
  task automatic run_req(input int id, input logic [7:0] mx, output logic [7:0] d,
                         output int rid, output int lat, output int ackv,
                         output int busy1, output int ack_after);
    @(negedge clk);
    if0.req[id] = 1'b1;
    if0.req_max[8*id +: 8] = mx;
    lat = 0;
    busy1 = 0;
    while (lat < Limit) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) busy1 = int'(if0.busy);
      if (if0.ack != '0) break;
    end
    ackv = int'(if0.ack);
    d    = if0.rnd_data;
    rid  = int'(if0.rnd_id);
    if0.req[id] = 1'b0;
    @(posedge clk); #1;
    ack_after = int'(if0.ack);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (lat < Limit) begin
      @(posedge clk); #1;
      lat++;
      if (if0.ack != '0) break;
    end
  endtask

  // Behavioural model: one bounded draw by rejection sampling from the spec rules.
  function automatic logic [7:0] m_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic m_draw(input logic [7:0] mx, input int max_tries, input logic [7:0] q_in,
                        output logic [7:0] q_out, output logic [7:0] res, output int tries);
    int m;
    int cand;
    m = 0;
    while (m < int'(mx)) m = m * 2 + 1;
    q_out = q_in;
    tries = 0;
    res = 8'h00;
    forever begin
      q_out = m_step(q_out);
      tries++;
      cand = int'(q_out) & m;
      if (cand <= int'(mx)) begin
        res = 8'(cand);
        break;
      end
      if (tries == max_tries) begin
        res = 8'(cand - (int'(mx) + 1));
        break;
      end
    end
  endtask

  function automatic logic [7:0] pick_max();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [7:0] d;
    int rid, lat, ackv, busy1, ack_after;
    logic [7:0] mq;
    int mptr;

    // Consecutive single requests after one reset; LFSR runs B5 6B D6 AC 59 B2 65 CB 96 2C.
    vecs[0] = '{0, 8'hFF, 8'hB5, 3};
    vecs[1] = '{1, 8'h04, 8'h03, 3};
    vecs[2] = '{2, 8'h0F, 8'h06, 3};
    vecs[3] = '{3, 8'h00, 8'h00, 3};
    vecs[4] = '{0, 8'h30, 8'h19, 3};
    vecs[5] = '{2, 8'h40, 8'h32, 3};
    vecs[6] = '{1, 8'h02, 8'h01, 3};
    vecs[7] = '{3, 8'h80, 8'h2C, 7};

    if0.req = '0;
    if0.req_max = '0;
    if1.req = '0;
    if1.req_max = '0;
    do_reset();
    check("reset_ack", int'(if0.ack), 0);
    check("reset_data", int'(if0.rnd_data), 0);
    check("reset_id", int'(if0.rnd_id), 0);
    check("reset_busy", int'(if0.busy), 0);

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].id, vecs[i].mx, d, rid, lat, ackv, busy1, ack_after);
      check($sformatf("vec%0d_data", i), int'(d), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_id", i), rid, vecs[i].id);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_ack", i), ackv, 1 << vecs[i].id);
      check($sformatf("vec%0d_busy", i), busy1, 1);
      check($sformatf("vec%0d_pulse", i), ack_after, 0);
    end

    // One rejection: 5 rejected, then 3 accepted.
    do_reset();
    run_req(1, 8'h04, d, rid, lat, ackv, busy1, ack_after);
    check("rej1_data", int'(d), 3);
    check("rej1_lat", lat, 5);
    check("rej1_id", rid, 1);

    // MAX_TRIES=1 instance: 5 rejected, fallback 5-5=0.
    do_reset();
    @(negedge clk);
    if1.req[0] = 1'b1;
    if1.req_max[7:0] = 8'h04;
    lat = 0;
    while (lat < Limit) begin
      @(posedge clk); #1;
      lat++;
      if (if1.ack != '0) break;
    end
    check("fallback_data", int'(if1.rnd_data), 0);
    check("fallback_lat", lat, 3);
    check("fallback_ack", int'(if1.ack), 1);
    if1.req = '0;

    // Three simultaneous requesters, each dropping on its own ack.
    do_reset();
    @(negedge clk);
    if0.req_max = {4{8'hFF}};
    if0.req = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] exp_d [3];
      exp_d = '{8'hB5, 8'h6B, 8'hD6};
      wait_ack(lat);
      check($sformatf("rr%0d_ack", k), int'(if0.ack), 1 << k);
      check($sformatf("rr%0d_data", k), int'(if0.rnd_data), int'(exp_d[k]));
      check($sformatf("rr%0d_id", k), int'(if0.rnd_id), k);
      if0.req[k] = 1'b0;
    end
    @(posedge clk); #1;

    // max=0 repeatedly still steps the LFSR once per request.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_req(2, 8'h00, d, rid, lat, ackv, busy1, ack_after);
      check($sformatf("zero%0d_data", k), int'(d), 0);
    end
    run_req(2, 8'hFF, d, rid, lat, ackv, busy1, ack_after);
    check("zero_next_data", int'(d), 8'hAC);

    // Reset while in CHECK: no ack, LFSR back to seed.
    do_reset();
    @(negedge clk);
    if0.req[0] = 1'b1;
    if0.req_max[7:0] = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ack", int'(if0.ack), 0);
    check("midrst_busy", int'(if0.busy), 0);
    if0.req = '0;
    ackv = 0;
    repeat (3) begin
      @(posedge clk); #1;
      ackv = ackv | int'(if0.ack);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      ackv = ackv | int'(if0.ack);
    end
    check("midrst_no_ack", ackv, 0);
    run_req(0, 8'hFF, d, rid, lat, ackv, busy1, ack_after);
    check("midrst_next_data", int'(d), 8'hB5);

`ifdef RNG_RESEED_EN
    // seed_load with seed=0 restores the reset sequence and blocks that cycle's grant.
    run_req(0, 8'hFF, d, rid, lat, ackv, busy1, ack_after);
    @(negedge clk);
    seed = 8'h00;
    seed_load = 1'b1;
    if0.req[0] = 1'b1;
    if0.req_max[7:0] = 8'hFF;
    @(posedge clk); #1;
    check("reseed_no_grant", int'(if0.busy), 0);
    seed_load = 1'b0;
    wait_ack(lat);
    check("reseed_data", int'(if0.rnd_data), 8'hB5);
    if0.req = '0;
    @(posedge clk); #1;
`endif

    // Randomized rounds of simultaneous requests against the model.
    do_reset();
    mq = 8'hDA;
    mptr = 0;
    for (int round = 0; round < 30; round++) begin
      logic [3:0] pend;
      logic [7:0] mmax [4];
      bit first;
      pend = 4'($urandom_range(1, 15));
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        mmax[i] = pick_max();
        if0.req_max[8*i +: 8] = mmax[i];
      end
      if0.req = pend;
      first = 1'b1;
      while (pend != 4'b0) begin
        int eid;
        int tries;
        logic [7:0] eres;
        eid = -1;
        for (int o = 0; o < 4; o++) begin
          if (eid < 0 && pend[(mptr + o) % 4]) eid = (mptr + o) % 4;
        end
        m_draw(mmax[eid], 4, mq, mq, eres, tries);
        wait_ack(lat);
        check("rand_ack", int'(if0.ack), 1 << eid);
        check("rand_data", int'(if0.rnd_data), int'(eres));
        check("rand_lat", lat, (first ? 1 : 2) + 2 * tries);
        if (if0.ack == '0) begin
          if0.req = '0;
          break;
        end
        first = 1'b0;
        if0.req[eid] = 1'b0;
        pend[eid] = 1'b0;
        mptr = (eid + 1) % 4;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Shares one 8-bit maximal-length LFSR random source between N_REQ game-logic requesters (encounter roll, damage variance, catch check, AI move pick).
- Round-robin arbitration; per-request bounded draw in [0, req_max] by masked rejection sampling with a deterministic fallback.
- Sits between the battle/overworld FSMs and the random core; the only block allowed to step the LFSR.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_TRIES, 4, total candidates drawn per request before fallback (1..15).
- SEED, 8'hDA, LFSR reset/default value; must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester request level; held high with req_max stable until that requester's ack.
- req_max  in  8*N_REQ  inclusive upper bound per requester; slice i = bits [8i+7:8i].
- ack  out  N_REQ  one-cycle pulse, one-hot, result valid for requester rnd_id.
- rnd_data  out  8  result; valid only while any ack bit is high, holds last value otherwise.
- rnd_id  out  $clog2(N_REQ)  index of the acknowledged requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: ack=0, rnd_data=0, rnd_id=0, busy=0, state=IDLE, LFSR=SEED, rr_ptr=0, tries=0.
- LFSR step: q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}; steps exactly once per candidate, never otherwise (sequence fully deterministic).
- mask = smallest 2^k-1 >= max (max=0 -> 0x00, 4 -> 0x07, 0x0F -> 0x0F, 255 -> 0xFF).
- FSM:
  - IDLE: if any req high, grant first requester at or after rr_ptr (wrapping); latch idx, max, mask; tries=0 -> DRAW.
  - DRAW: step LFSR; tries++ -> CHECK.
  - CHECK: cand = q & mask. If cand <= max -> result=cand. Else if tries == MAX_TRIES -> result = cand - (max+1) (always <= max, since mask <= 2*max+1). Otherwise -> DRAW.
  - RESP: ack[idx]=1, rnd_id=idx, rnd_data=result; rr_ptr=idx+1 mod N_REQ -> IDLE.
- Latency: req sampled high in IDLE at edge 0 -> ack high in cycle 3 best case; +2 cycles per rejection.
- Requester drops req on the edge where it sees ack. A req still high in the following IDLE cycle is a new request.
- req deasserted before ack: undefined for requester; the block still completes and pulses ack.
- max=0 -> result 0 (LFSR still steps once). max=255 -> first candidate always accepted (LFSR never zero).
- Simultaneous requests: serviced in round-robin order, one at a time. No requester waits more than N_REQ-1 grants.
- Reset mid-operation: immediate return to reset values; no ack issued for the in-flight request.

Optional Feature:
- RNG_RESEED_EN defined: adds ports seed_load (in, 1) and seed (in, 8).
  - seed_load high in IDLE: LFSR <= seed, or SEED if seed==0; no grant that cycle.
  - seed_load outside IDLE: ignored.
- Undefined: ports absent; LFSR is seeded only by reset.

Decomposition:
- Package rng_pkg:
  - LFSR width 8, default seed 8'hDA, tap list.
  - state enum {IDLE, DRAW, CHECK, RESP}.
  - function mask_for(max).
- One sub-module, rng_lfsr_core: the 8-bit LFSR with en and optional load. The arbiter FSM stays in rng_arbiter.

Test Plan:
- Reset, req[0]=1, max=0xFF -> ack[0] in cycle 3, rnd_data=0xB5, rnd_id=0.
- Reset, req[1]=1, max=0x04 -> candidate 0xB5&7=5 rejected, 0x6B&7=3 accepted; ack[1] in cycle 5, rnd_data=3.
- MAX_TRIES=1, reset, max=0x04 -> candidate 5 rejected, fallback 5-5=0; ack in cycle 3, rnd_data=0.
- Reset, req=4'b0111, all max=0xFF, each dropped on its ack -> acks 0,1,2 in order, data 0xB5, 0x6B, 0xD6; no grant overlap.
- Reset, max=0, repeated requests -> rnd_data always 0; next request with max=0xFF returns the following LFSR value in sequence.
- rst pulsed during CHECK -> no ack; next max=0xFF request returns 0xB5. With RNG_RESEED_EN: seed_load with seed=0 behaves identically to reset.
